wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback stream and the multi-cycle multiply/divide unit (MDU) result stream.
- MDU results are buffered in a small FIFO. Pipeline writes have priority.
- A starvation guard stalls the pipeline for one cycle so that a buffered MDU result can drain.
- Sits between the WB stage / MDU and the register file write port.

---
 rtl/wb_port_arbiter.sv | 127 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results
// are buffered in a small FIFO and drained on idle cycles or by a starvation guard.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pipe_valid,
    input  logic [REG_W-1:0]            pipe_reg,
    input  logic [DATA_W-1:0]           pipe_data,
    output logic                        pipe_stall,
    input  logic                        mdu_valid,
    output logic                        mdu_ready,
    input  logic [REG_W-1:0]            mdu_reg,
    input  logic [DATA_W-1:0]           mdu_data,
    output logic                        rf_we,
    output logic [REG_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STARVE_MAX);

    logic [REG_W-1:0]  mem_reg_q  [FIFO_DEPTH];
    logic [REG_W-1:0]  mem_reg_d  [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic fifo_empty;
    logic force_mdu;
    logic grant_pipe;
    logic pop;
    logic push;

    // Grant selection; the starvation guard overrides pipeline priority.
    always_comb begin
        fifo_empty = (count_q == '0);
        force_mdu  = !fifo_empty && (starve_cnt_q == SC_MAX);
        grant_pipe = pipe_valid && !force_mdu;
        pop        = !grant_pipe && !fifo_empty;
        mdu_ready  = (count_q != DEPTH_C);
        push       = mdu_valid && mdu_ready;
        pipe_stall = pipe_valid && force_mdu;
    end

    always_comb begin
        mem_reg_d    = mem_reg_q;
        mem_data_d   = mem_data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        starve_cnt_d = starve_cnt_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;

        if (push) begin
            mem_reg_d[wr_ptr_q]  = mdu_reg;
            mem_data_d[wr_ptr_q] = mdu_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (fifo_empty || pop) begin
            starve_cnt_d = '0;
        end else if (grant_pipe && (starve_cnt_q != SC_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        // A write to r0 still consumes its slot but never asserts the enable.
        if (grant_pipe) begin
            rf_we_d    = (pipe_reg != '0);
            rf_waddr_d = pipe_reg;
            rf_wdata_d = pipe_data;
        end else if (pop) begin
            rf_we_d    = (mem_reg_q[rd_ptr_q] != '0);
            rf_waddr_d = mem_reg_q[rd_ptr_q];
            rf_wdata_d = mem_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg_q    <= '{default: '0};
            mem_data_q   <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            mem_reg_q    <= mem_reg_d;
            mem_data_q   <= mem_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: every accepted write is queued per source
// and each rf write must match the head of the pipeline or MDU queue.
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int E_W    = REG_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pipe_valid;
    logic [REG_W-1:0]  pipe_reg;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_stall;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [REG_W-1:0]  mdu_reg;
    logic [DATA_W-1:0] mdu_data;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [1:0]        fifo_count;

    wb_port_arbiter #(.DATA_W(32), .REG_W(5), .FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
        .pipe_stall(pipe_stall),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [E_W-1:0] pipe_q[$];
    logic [E_W-1:0] mdu_q[$];
    logic           last_stall, last_ready, p_acc, m_acc;
    logic [31:0]    pseq;
    int             mi;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cyc();
        logic [E_W-1:0] obs;
        logic           hit;
        #1;
        last_stall = pipe_stall;
        last_ready = mdu_ready;
        p_acc = pipe_valid && !pipe_stall;
        m_acc = mdu_valid && mdu_ready;
        if (p_acc && pipe_reg != '0) pipe_q.push_back({pipe_reg, pipe_data});
        if (m_acc && mdu_reg != '0)  mdu_q.push_back({mdu_reg, mdu_data});
        @(posedge clk);
        #1;
        if (rf_we) begin
            obs = {rf_waddr, rf_wdata};
            hit = 1'b0;
            if (mdu_q.size() > 0 && mdu_q[0] === obs) begin
                hit = 1'b1;
                void'(mdu_q.pop_front());
            end else if (pipe_q.size() > 0 && pipe_q[0] === obs) begin
                hit = 1'b1;
                void'(pipe_q.pop_front());
            end
            checks++;
            assert (hit) else begin
                failures++;
                $error("FAIL rf_write observed=%0h mdu_head=%0h pipe_head=%0h",
                       obs, (mdu_q.size() > 0) ? mdu_q[0] : '0,
                       (pipe_q.size() > 0) ? pipe_q[0] : '0);
            end
        end
    endtask

    task automatic idle();
        pipe_valid = 1'b0;
        mdu_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        pipe_reg = '0; pipe_data = '0; mdu_reg = '0; mdu_data = '0;
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_count", fifo_count, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", mdu_ready, 1);

        // single pipeline write
        pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_data = 32'h0000_00AA;
        cyc();
        check("t1_stall", last_stall, 0);
        idle();
        check("t1_we", rf_we, 1);
        check("t1_waddr", rf_waddr, 5);
        check("t1_wdata", rf_wdata, 32'hAA);

        // single MDU result on an idle pipeline
        mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'h1234_5678;
        cyc();
        check("t2_ready", last_ready, 1);
        idle();
        check("t2_count1", fifo_count, 1);
        check("t2_we_early", rf_we, 0);
        cyc();
        check("t2_count0", fifo_count, 0);
        check("t2_we", rf_we, 1);
        check("t2_waddr", rf_waddr, 7);
        check("t2_wdata", rf_wdata, 32'h1234_5678);

        // starvation guard: four pipeline grants, then one forced MDU grant
        mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'hB000_0001;
        cyc();
        mdu_valid = 1'b0;
        pseq = 32'h5000_0000;
        pipe_valid = 1'b1; pipe_reg = 5'd3; pipe_data = pseq;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check("t3_stall", last_stall, (i == 5));
            if (i == 5) check("t3_mdu_addr", rf_waddr, 9);
            if (i == 6) check("t3_held_data", rf_wdata, 32'h5000_0004);
            if (p_acc) begin pseq++; pipe_data = pseq; end
        end
        idle();
        check("t3_starve", dut.starve_cnt_q, 0);
        check("t3_pipe_q", pipe_q.size(), 0);
        check("t3_mdu_q", mdu_q.size(), 0);

        // back-to-back MDU pushes against a continuously busy pipeline
        pseq = 32'h6000_0000;
        pipe_valid = 1'b1; pipe_reg = 5'd4; pipe_data = pseq;
        mi = 0;
        mdu_valid = 1'b1; mdu_reg = 5'd10; mdu_data = 32'hC000_0001;
        for (int i = 0; i < 24; i++) begin
            cyc();
            if (i <= 6) check("t4_ready", last_ready, (i < 2 || i >= 6));
            if (p_acc) begin pseq++; pipe_data = pseq; end
            if (m_acc) begin
                mi++;
                if (mi == 3) mdu_valid = 1'b0;
                else begin
                    mdu_reg  = 5'(10 + mi);
                    mdu_data = 32'hC000_0001 + 32'(mi);
                end
            end
        end
        idle();
        for (int i = 0; i < 4; i++) cyc();
        check("t4_pushed", mi, 3);
        check("t4_mdu_q", mdu_q.size(), 0);
        check("t4_pipe_q", pipe_q.size(), 0);
        check("t4_count", fifo_count, 0);

        // writes to r0 never raise the enable but the FIFO still drains
        pipe_valid = 1'b1; pipe_reg = 5'd0; pipe_data = 32'hFFFF_FFFF;
        cyc();
        idle();
        check("t5_pipe_r0", rf_we, 0);
        mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'h0000_000D;
        cyc();
        idle();
        check("t5_count1", fifo_count, 1);
        cyc();
        check("t5_count0", fifo_count, 0);
        check("t5_mdu_r0", rf_we, 0);
        cyc();
        check("t5_we_after", rf_we, 0);

        // asynchronous reset with two buffered MDU results
        pipe_valid = 1'b1; pipe_reg = 5'd2; pipe_data = 32'h7000_0000;
        mdu_valid = 1'b1; mdu_reg = 5'd20; mdu_data = 32'hE000_0001;
        cyc();
        mdu_reg = 5'd21; mdu_data = 32'hE000_0002; pipe_data = 32'h7000_0001;
        cyc();
        idle();
        #2;
        check("t6_count_pre", fifo_count, 2);
        check("t6_we_pre", rf_we, 1);
        rst_n = 1'b0;
        #1;
        check("t6_we_rst", rf_we, 0);
        check("t6_count_rst", fifo_count, 0);
        pipe_q.delete();
        mdu_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("t6_no_stale", rf_we, 0);
        end
        check("t6_count", fifo_count, 0);
        check("t6_ready", mdu_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
